// File: rtl/requant_param_stage.sv
// requant_param_stage: adds per-channel bias and attaches quant params to drained accumulators.
// Define REQUANT_BIAS_SAT_EN to saturate acc+bias instead of wrapping.
module requant_param_stage #(
  parameter int NUM_CH = 64,
  parameter int CH_W   = $clog2(NUM_CH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cfg_we,
  input  logic [CH_W-1:0] cfg_addr,
  input  logic [31:0]     cfg_bias,
  input  logic [31:0]     cfg_mult,
  input  logic [5:0]      cfg_shift,
  input  logic            start,
  input  logic [CH_W:0]   num_channels,
  input  logic            last_layer,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_acc,
  input  logic            in_last,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_acc,
  output logic [31:0]     out_mult,
  output logic [5:0]      out_shift,
  output logic            out_czp,
  output logic [CH_W-1:0] out_ch,
  output logic            busy,
  output logic            done
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state_q, state_d;
  logic [CH_W:0] num_q, num_d;
  logic czp_q, czp_d, done_q, done_d;
  logic [CH_W-1:0] ch_q, ch_d;
  logic s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
  logic [31:0] s1_acc_q, s1_acc_d, s1_bias_q, s1_bias_d, s1_mult_q, s1_mult_d;
  logic [5:0] s1_shift_q, s1_shift_d;
  logic [CH_W-1:0] s1_ch_q, s1_ch_d;
  logic [31:0] s2_acc_q, s2_acc_d, s2_mult_q, s2_mult_d;
  logic [5:0] s2_shift_q, s2_shift_d;
  logic s2_czp_q, s2_czp_d;
  logic [CH_W-1:0] s2_ch_q, s2_ch_d;
  logic [31:0] bias_mem [NUM_CH];
  logic [31:0] mult_mem [NUM_CH];
  logic [5:0] shift_mem [NUM_CH];
  logic adv, acc_hs, start_ok, empty;
  logic [31:0] sum_r;
`ifdef REQUANT_BIAS_SAT_EN
  logic [32:0] sum;
`endif
  always_comb begin
    adv = !s2_valid_q | out_ready;
    in_ready = (state_q == RUN) & adv;
    acc_hs = in_valid & in_ready;
    empty = !s1_valid_q & !s2_valid_q;
    start_ok = (state_q == IDLE) && start && (num_channels != '0) &&
               (num_channels <= (CH_W+1)'(NUM_CH));
`ifdef REQUANT_BIAS_SAT_EN
    sum = {s1_acc_q[31], s1_acc_q} + {s1_bias_q[31], s1_bias_q};
    sum_r = (sum[32] != sum[31]) ? (sum[32] ? 32'h8000_0000 : 32'h7FFF_FFFF) : sum[31:0];
`else
    sum_r = s1_acc_q + s1_bias_q;
`endif
    state_d = start_ok ? RUN :
              (state_q == RUN && acc_hs && in_last) ? DRAIN :
              (state_q == DRAIN && empty) ? IDLE : state_q;
    done_d = (state_q == DRAIN) && empty;
    num_d = start_ok ? num_channels : num_q;
    czp_d = start_ok ? last_layer : czp_q;
    ch_d = start_ok ? '0 :
           acc_hs ? (({1'b0, ch_q} == num_q - 1'b1) ? '0 : ch_q + 1'b1) : ch_q;
    s1_valid_d = adv ? acc_hs : s1_valid_q;
    s1_acc_d = adv ? in_acc : s1_acc_q;
    s1_ch_d = adv ? ch_q : s1_ch_q;
    s1_bias_d = adv ? bias_mem[ch_q] : s1_bias_q;
    s1_mult_d = adv ? mult_mem[ch_q] : s1_mult_q;
    s1_shift_d = adv ? shift_mem[ch_q] : s1_shift_q;
    s2_valid_d = adv ? s1_valid_q : s2_valid_q;
    s2_acc_d = adv ? sum_r : s2_acc_q;
    s2_mult_d = adv ? s1_mult_q : s2_mult_q;
    s2_shift_d = adv ? s1_shift_q : s2_shift_q;
    s2_czp_d = adv ? czp_q : s2_czp_q;
    s2_ch_d = adv ? s1_ch_q : s2_ch_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      num_q <= '0;
      czp_q <= 1'b0;
      done_q <= 1'b0;
      ch_q <= '0;
      s1_valid_q <= 1'b0;
      s1_acc_q <= '0;
      s1_bias_q <= '0;
      s1_mult_q <= '0;
      s1_shift_q <= '0;
      s1_ch_q <= '0;
      s2_valid_q <= 1'b0;
      s2_acc_q <= '0;
      s2_mult_q <= '0;
      s2_shift_q <= '0;
      s2_czp_q <= 1'b0;
      s2_ch_q <= '0;
    end else begin
      state_q <= state_d;
      num_q <= num_d;
      czp_q <= czp_d;
      done_q <= done_d;
      ch_q <= ch_d;
      s1_valid_q <= s1_valid_d;
      s1_acc_q <= s1_acc_d;
      s1_bias_q <= s1_bias_d;
      s1_mult_q <= s1_mult_d;
      s1_shift_q <= s1_shift_d;
      s1_ch_q <= s1_ch_d;
      s2_valid_q <= s2_valid_d;
      s2_acc_q <= s2_acc_d;
      s2_mult_q <= s2_mult_d;
      s2_shift_q <= s2_shift_d;
      s2_czp_q <= s2_czp_d;
      s2_ch_q <= s2_ch_d;
    end
  end
  // Table has no reset; writes are accepted only between passes.
  always_ff @(posedge clk) begin
    if (cfg_we && state_q == IDLE) begin
      bias_mem[cfg_addr] <= cfg_bias;
      mult_mem[cfg_addr] <= cfg_mult;
      shift_mem[cfg_addr] <= cfg_shift;
    end
  end
  assign busy = state_q != IDLE;
  assign done = done_q;
  assign out_valid = s2_valid_q;
  assign out_acc = s2_acc_q;
  assign out_mult = s2_mult_q;
  assign out_shift = s2_shift_q;
  assign out_czp = s2_czp_q;
  assign out_ch = s2_ch_q;
endmodule

// File: tb/tb_requant_param_stage.sv
// tb_requant_param_stage: randomized bench with a queue-based reference model of the param stage.
module tb_requant_param_stage;
  localparam int NUM_CH = 64;
  localparam int CH_W = 6;
  logic clk, rst_n, cfg_we, start, last_layer, in_valid, in_ready, in_last;
  logic out_valid, out_ready, out_czp, busy, done;
  logic [CH_W-1:0] cfg_addr, out_ch;
  logic [31:0] cfg_bias, cfg_mult, in_acc, out_acc, out_mult;
  logic [5:0] cfg_shift, out_shift;
  logic [CH_W:0] num_channels;

  requant_param_stage #(.NUM_CH(NUM_CH), .CH_W(CH_W)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_bias(cfg_bias),
    .cfg_mult(cfg_mult), .cfg_shift(cfg_shift), .start(start), .num_channels(num_channels),
    .last_layer(last_layer), .in_valid(in_valid), .in_ready(in_ready), .in_acc(in_acc),
    .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready), .out_acc(out_acc),
    .out_mult(out_mult), .out_shift(out_shift), .out_czp(out_czp), .out_ch(out_ch),
    .busy(busy), .done(done));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] acc;
    logic [31:0] mult;
    logic [5:0] shift;
    logic czp;
    logic [CH_W-1:0] ch;
    int cyc;
  } exp_t;
  exp_t q[$];
  exp_t e;
  logic [31:0] m_bias [NUM_CH];
  logic [31:0] m_mult [NUM_CH];
  logic [5:0] m_shift [NUM_CH];
  int m_num = 1, m_ch = 0;
  bit m_czp = 0;
  int cmp_n = 0, fail_n = 0, cyc = 0, done_cnt = 0;
  bit lat_chk = 0, prev_stall = 0;
  logic [77:0] prev, cur;
  logic [31:0] obs_acc[$];
  int obs_ch[$];
  logic [31:0] acc_q[$];

  function automatic logic [31:0] badd(input logic [31:0] a, input logic [31:0] b);
    longint s;
    s = longint'($signed(a)) + longint'($signed(b));
`ifdef REQUANT_BIAS_SAT_EN
    if (s > 64'sd2147483647) return 32'h7FFF_FFFF;
    if (s < -64'sd2147483648) return 32'h8000_0000;
`endif
    return s[31:0];
  endfunction

  task automatic chk(input string nm, input longint a, input longint x);
    cmp_n++;
    if (a !== x) begin
      fail_n++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, a, a, x, x);
    end
  endtask

  // Reference: every accepted beat yields one output, channel = beat index mod num_channels.
  always @(negedge clk) begin
    cyc++;
    cur = {out_valid, out_acc, out_mult, out_shift, out_czp, out_ch};
    if (!rst_n) prev_stall = 0;
    else begin
      if (prev_stall) begin
        cmp_n++;
        if (cur !== prev) begin
          fail_n++;
          $display("FAIL stall_hold: got %h expected %h", cur, prev);
        end
      end
      if (out_valid && !out_ready) chk("stall_in_ready", longint'(in_ready), 0);
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          cmp_n++;
          fail_n++;
          $display("FAIL extra_beat: got acc %h ch %0d expected no output", out_acc, out_ch);
        end else begin
          e = q.pop_front();
          cmp_n++;
          if (cur !== {1'b1, e.acc, e.mult, e.shift, e.czp, e.ch}) begin
            fail_n++;
            $display("FAIL beat: got acc %h mult %h sh %h czp %b ch %0d expected acc %h mult %h sh %h czp %b ch %0d",
                     out_acc, out_mult, out_shift, out_czp, out_ch, e.acc, e.mult, e.shift, e.czp, e.ch);
          end
          if (lat_chk) chk("latency", longint'(cyc - e.cyc), 2);
          obs_acc.push_back(out_acc);
          obs_ch.push_back(int'(out_ch));
        end
      end
      if (in_valid && in_ready) begin
        q.push_back('{badd(in_acc, m_bias[m_ch]), m_mult[m_ch], m_shift[m_ch], m_czp, CH_W'(m_ch), cyc});
        m_ch = (m_ch + 1) % m_num;
      end
      chk("buffered_le_2", longint'(q.size() > 2), 0);
      if (done) done_cnt++;
      prev_stall = out_valid && !out_ready;
      prev = cur;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input int a, input logic [31:0] b, input logic [31:0] m, input logic [5:0] s);
    cfg_we = 1; cfg_addr = CH_W'(a); cfg_bias = b; cfg_mult = m; cfg_shift = s;
    tick();
    cfg_we = 0;
    m_bias[a] = b; m_mult[a] = m; m_shift[a] = s;
  endtask

  task automatic start_pass(input int n, input bit ll, input bit ok);
    start = 1; num_channels = (CH_W+1)'(n); last_layer = ll;
    tick();
    start = 0;
    if (ok) begin m_num = n; m_czp = ll; m_ch = 0; end
    obs_acc.delete();
    obs_ch.delete();
  endtask

  task automatic run_pass(input int n, input int vpct, input int rpct, input int stall_at, input bit wr_busy);
    int i, t, d0;
    bit hs;
    i = 0; t = 0; d0 = done_cnt;
    while (i < n && t < 20000) begin
      in_valid = $urandom_range(99) < vpct;
      in_acc = (i < acc_q.size()) ? acc_q[i] : $urandom;
      in_last = (i == n - 1);
      out_ready = (t >= stall_at && t < stall_at + 5) ? 1'b0 : ($urandom_range(99) < rpct);
      start = (t == 2);
      num_channels = (CH_W+1)'($urandom_range(1, NUM_CH));
      cfg_we = wr_busy && t == 1;
      cfg_addr = '0; cfg_bias = $urandom; cfg_mult = $urandom; cfg_shift = 6'($urandom_range(63));
      @(negedge clk);
      hs = in_valid && in_ready;
      tick();
      t++;
      if (hs) i++;
    end
    in_valid = 0; in_last = 0; start = 0; cfg_we = 0;
    chk("beats_accepted", longint'(i), longint'(n));
    t = 0;
    while (busy && t < 1000) begin
      out_ready = $urandom_range(99) < rpct;
      tick();
      t++;
    end
    out_ready = 1;
    tick();
    tick();
    chk("busy_drop", longint'(busy), 0);
    chk("done_once", longint'(done_cnt - d0), 1);
    chk("all_drained", longint'(q.size()), 0);
    acc_q.delete();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    rst_n = 0; cfg_we = 0; cfg_addr = '0; cfg_bias = '0; cfg_mult = '0; cfg_shift = '0;
    start = 0; num_channels = '0; last_layer = 0; in_valid = 0; in_acc = '0; in_last = 0; out_ready = 0;
    #23;
    chk("reset_outs", longint'({out_valid, out_acc, out_mult, out_shift, out_czp, out_ch, in_ready, busy, done}), 0);
    @(negedge clk);
    rst_n = 1;
    tick();

    // basic pass; ch1 written in the same cycle as start
    cfg(0, 32'd100, 32'd1073741824, 6'd1);
    cfg_we = 1; cfg_addr = 6'd1; cfg_bias = -32'sd50; cfg_mult = 32'd2; cfg_shift = 6'h3E;
    start_pass(2, 0, 1);
    cfg_we = 0;
    m_bias[1] = -32'sd50; m_mult[1] = 32'd2; m_shift[1] = 6'h3E;
    acc_q = '{32'd10, 32'd20, 32'd30};
    lat_chk = 1;
    run_pass(3, 100, 100, -100, 0);
    lat_chk = 0;
    chk("t1_acc0", longint'(obs_acc[0]), 110);
    chk("t1_acc1", longint'(obs_acc[1]), longint'(32'hFFFF_FFE2));
    chk("t1_acc2", longint'(obs_acc[2]), 130);
    chk("t1_ch1", longint'(obs_ch[1]), 1);
    chk("t1_ch2", longint'(obs_ch[2]), 0);

    // backpressure with a full stream
    cfg(2, 32'd7, 32'd3, 6'd5);
    start_pass(3, 0, 1);
    run_pass(12, 100, 100, 4, 0);

    // write to ch0 while busy is dropped
    start_pass(2, 1, 1);
    run_pass(4, 100, 100, -100, 1);
    start_pass(1, 0, 1);
    acc_q = '{32'd5};
    run_pass(1, 100, 100, -100, 0);
    chk("t4_old_bias", longint'(obs_acc[0]), 105);
    start_pass(0, 0, 0);
    chk("t4_num0_busy", longint'(busy), 0);
    start_pass(NUM_CH + 1, 0, 0);
    chk("t4_num65_busy", longint'(busy), 0);
    chk("t4_num65_ready", longint'(in_ready), 0);

    // bias overflow in both directions
    cfg(0, 32'd32, 32'd9, 6'd3);
    cfg(1, -32'sd16, 32'd9, 6'd3);
    start_pass(2, 0, 1);
    acc_q = '{32'h7FFF_FFF0, 32'h8000_0005};
    run_pass(2, 100, 100, -100, 0);
`ifdef REQUANT_BIAS_SAT_EN
    chk("t3_pos_ovf", longint'(obs_acc[0]), longint'(32'h7FFF_FFFF));
    chk("t3_neg_ovf", longint'(obs_acc[1]), longint'(32'h8000_0000));
`else
    chk("t3_pos_ovf", longint'(obs_acc[0]), longint'(32'h8000_0010));
    chk("t3_neg_ovf", longint'(obs_acc[1]), longint'(32'h7FFF_FFF5));
`endif

    // reset with two beats in flight
    for (int i = 0; i < 4; i++) cfg(i, $urandom, $urandom, 6'($urandom_range(63)));
    start_pass(4, 0, 1);
    d0 = done_cnt;
    in_valid = 1; out_ready = 1;
    tick();
    tick();
    in_valid = 0;
    chk("t5_inflight", longint'(out_valid), 1);
    #2;
    rst_n = 0;
    q.delete();
    #1;
    chk("t5_rst_valid", longint'(out_valid), 0);
    chk("t5_rst_busy", longint'(busy), 0);
    chk("t5_rst_ready", longint'(in_ready), 0);
    tick();
    @(negedge clk);
    rst_n = 1;
    tick();
    tick();
    chk("t5_no_done", longint'(done_cnt - d0), 0);
    for (int i = 0; i < 4; i++) cfg(i, $urandom, $urandom, 6'($urandom_range(63)));
    start_pass(4, 1, 1);
    run_pass(10, 70, 70, -100, 0);

    // full-depth wrap
    for (int i = 0; i < NUM_CH; i++) cfg(i, $urandom, $urandom, 6'($urandom_range(63)));
    start_pass(NUM_CH, 0, 1);
    run_pass(2 * NUM_CH, 80, 80, -100, 0);
    chk("t6_ch63", longint'(obs_ch[NUM_CH - 1]), NUM_CH - 1);
    chk("t6_wrap", longint'(obs_ch[NUM_CH]), 0);
    chk("t6_last", longint'(obs_ch[2 * NUM_CH - 1]), NUM_CH - 1);

    // randomized passes
    for (int p = 0; p < 6; p++) begin
      int nch;
      nch = $urandom_range(1, NUM_CH);
      for (int i = 0; i < nch; i++) cfg(i, $urandom, $urandom, 6'($urandom_range(63)));
      start_pass(nch, 1'($urandom_range(1)), 1);
      run_pass($urandom_range(1, 150), $urandom_range(30, 100), $urandom_range(30, 100),
               $urandom_range(0, 40), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, fail_n);
    $finish;
  end
endmodule

// File: doc/requant_param_stage.md
Name: requant_param_stage

Overview:
- Stage directly upstream of the requantize/ReLU6 unit. Consumes int32 MAC accumulators from the array drain path, one per output channel in round-robin order.
- Adds the per-channel int32 bias and attaches that channel's quant multiplier, shift and zero-point select, aligned to the accumulator.
- Holds a small per-channel parameter table, loaded before each layer.
- Output feeds the requantize unit's acc/quant_mult/shift/choose_zero_point inputs directly.

Parameters:
- NUM_CH, 64: parameter table depth, i.e. the maximum number of output channels.
- CH_W, $clog2(NUM_CH): channel index width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cfg_we  in  1  parameter table write strobe
- cfg_addr  in  CH_W  table entry written
- cfg_bias  in  32  signed bias
- cfg_mult  in  32  signed quant multiplier
- cfg_shift  in  6  signed shift
- start  in  1  begin a layer pass (pulse)
- num_channels  in  CH_W+1  channels in this layer, 1..NUM_CH; sampled on start
- last_layer  in  1  zero-point select for the whole pass; sampled on start
- in_valid  in  1  accumulator valid
- in_ready  out  1  stage accepts accumulator
- in_acc  in  32  signed accumulator
- in_last  in  1  final accumulator of the pass
- out_valid  out  1  output valid
- out_ready  in  1  downstream accepts
- out_acc  out  32  acc + bias
- out_mult  out  32  multiplier for out_acc's channel
- out_shift  out  6  shift for out_acc's channel
- out_czp  out  1  zero-point select (latched last_layer)
- out_ch  out  CH_W  channel index of out_acc
- busy  out  1  pass in progress
- done  out  1  one-cycle pulse when the pass has fully drained

Behaviour:
- Reset (async, rst_n=0):
  - FSM goes to IDLE; channel counter = 0; both pipeline valids = 0.
  - All outputs = 0, including in_ready, out_valid, busy and done.
  - Table contents are undefined after reset and must be reloaded.
- FSM states: IDLE, RUN, DRAIN.
  - IDLE -> RUN when start=1 and num_channels is between 1 and NUM_CH. The same edge latches num_channels and last_layer and clears the channel counter.
  - start with num_channels=0 or >NUM_CH is ignored; FSM stays in IDLE.
  - start outside IDLE is ignored.
  - RUN -> DRAIN on an accepted beat (in_valid & in_ready) that has in_last=1.
  - DRAIN -> IDLE when both pipeline stages are empty; done=1 for exactly that one cycle.
- busy = (state != IDLE).
- Config writes:
  - cfg_we is honoured only while busy=0; writes while busy are dropped.
  - A write in the same cycle as an accepted start is still honoured.
- Handshake:
  - Pipeline advance enable adv = !s2_valid | out_ready.
  - in_ready = (state==RUN) & adv.
  - Data moves only when adv=1; all stage registers hold while adv=0.
  - out_* hold stable while out_valid=1 and out_ready=0.
- Pipeline, 2 stages:
  - S1: registers in_acc and the channel index; table read is synchronous (registered) at that index.
  - S2: registers acc+bias, mult, shift, czp and ch.
  - Latency from accepted input to out_valid = 2 cycles when out_ready is held 1.
  - Throughput 1 beat/cycle.
- Channel counter:
  - Increments on each accepted beat.
  - Wraps from num_channels-1 to 0.
  - in_last does not reset the counter mid-sequence; it only ends the pass.
- Arithmetic:
  - Bias add is 33-bit signed internally, then reduced to 32 bits per the optional feature.
  - mult and shift pass through unmodified.
- Reset mid-operation: all in-flight beats are discarded; done does not pulse.

Optional Feature:
- Macro: REQUANT_BIAS_SAT_EN
- Defined: acc+bias saturates to 32'sh7FFFFFFF / 32'sh80000000 on overflow.
- Undefined: two's-complement wrap (low 32 bits of the sum).
- No other behaviour differs between the two builds.

Test Plan:
1. Load ch0 {bias=100, mult=1073741824, shift=1}, ch1 {bias=-50, mult=2, shift=-2}. start with num_channels=2, last_layer=0. Send acc 10, 20, 30 (in_last on 30), out_ready=1 -> outputs (110, ch0), (-30, ch1), (130, ch0), each with the matching mult/shift and out_czp=0. Each output appears 2 cycles after its input; done pulses once; busy drops.
2. Backpressure: out_ready=0 for 5 cycles with a stream in flight -> at most 2 beats buffered; in_ready=0; out_* stable. After release, no beat is lost or duplicated and channel order is preserved.
3. acc=32'sh7FFFFFF0, bias=32 -> out_acc=32'sh7FFFFFFF with REQUANT_BIAS_SAT_EN defined, 32'sh80000010 without it.
4. cfg_we to ch0 while busy=1 -> table unchanged, seen on the next pass. start with num_channels=0 -> FSM stays in IDLE, busy stays 0.
5. Assert rst_n=0 with 2 beats in flight -> out_valid, busy, in_ready all 0 immediately. No done pulse. After rst_n rises, a new start/reload works normally.
6. num_channels=NUM_CH, send 2*NUM_CH beats -> out_ch runs 0..NUM_CH-1 twice and wraps correctly.
